// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between fetch and data requesters with fixed wait states.
// Optional MEM_ARBITER_FAIR_EN: a pending fetch wins the arbitration that follows each data access.
module memory_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 3
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Inst_Req,
    input  logic [ADDR_WIDTH-1:0] i_Inst_Address,
    output logic [DATA_WIDTH-1:0] o_Inst_Data,
    output logic                  o_Inst_Ready,
    input  logic                  i_Data_Read_Enable,
    input  logic                  i_Data_Write_Enable,
    input  logic [ADDR_WIDTH-1:0] i_Data_Address,
    input  logic [DATA_WIDTH-1:0] i_Data_Write_Data,
    output logic [DATA_WIDTH-1:0] o_Data_Read_Data,
    output logic                  o_Data_Ready,
    output logic                  o_Freeze,
    output logic [ADDR_WIDTH-1:0] o_Mem_Address,
    output logic [DATA_WIDTH-1:0] o_Mem_Write_Data,
    output logic                  o_Mem_Read_Enable,
    output logic                  o_Mem_Write_Enable,
    input  logic [DATA_WIDTH-1:0] i_Mem_Read_Data
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [3:0] LAST = 4'(WAIT_STATES - 1);

    logic [1:0] state;
    logic [3:0] count;
    logic       grant_data;
    logic       grant_write;
    logic       data_req;
    logic       pick_data;
    logic       pick_write;

    assign data_req = i_Data_Read_Enable | i_Data_Write_Enable;
`ifdef MEM_ARBITER_FAIR_EN
    logic last_data;
    // A fetch waiting behind a completed data access gets the next slot.
    assign pick_data = data_req & ~(last_data & i_Inst_Req);
`else
    assign pick_data = data_req;
`endif
    assign pick_write = pick_data & i_Data_Write_Enable;
    assign o_Freeze   = data_req & ~o_Data_Ready;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state              <= IDLE;
            count              <= '0;
            grant_data         <= 1'b0;
            grant_write        <= 1'b0;
            o_Inst_Data        <= '0;
            o_Inst_Ready       <= 1'b0;
            o_Data_Read_Data   <= '0;
            o_Data_Ready       <= 1'b0;
            o_Mem_Address      <= '0;
            o_Mem_Write_Data   <= '0;
            o_Mem_Read_Enable  <= 1'b0;
            o_Mem_Write_Enable <= 1'b0;
`ifdef MEM_ARBITER_FAIR_EN
            last_data          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_data | i_Inst_Req) begin
                        grant_data         <= pick_data;
                        grant_write        <= pick_write;
                        o_Mem_Address      <= pick_data ? i_Data_Address : i_Inst_Address;
                        o_Mem_Write_Data   <= pick_write ? i_Data_Write_Data : o_Mem_Write_Data;
                        o_Mem_Write_Enable <= pick_write;
                        o_Mem_Read_Enable  <= ~pick_write;
                        count              <= '0;
                        state              <= BUSY;
                    end
                end
                BUSY: begin
                    if (count == LAST) begin
                        o_Data_Read_Data   <= (grant_data & ~grant_write) ? i_Mem_Read_Data : o_Data_Read_Data;
                        o_Inst_Data        <= grant_data ? o_Inst_Data : i_Mem_Read_Data;
                        o_Mem_Read_Enable  <= 1'b0;
                        o_Mem_Write_Enable <= 1'b0;
                        o_Data_Ready       <= grant_data;
                        o_Inst_Ready       <= ~grant_data;
`ifdef MEM_ARBITER_FAIR_EN
                        last_data          <= grant_data;
`endif
                        state              <= DONE;
                    end else begin
                        count <= count + 4'd1;
                    end
                end
                DONE: begin
                    o_Data_Ready <= 1'b0;
                    o_Inst_Ready <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter with directed and randomized traffic.
// Expected arbitration follows MEM_ARBITER_FAIR_EN when the macro is defined.
module tb_memory_arbiter;
    localparam int W = 3;
`ifdef MEM_ARBITER_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] wd;
        logic [31:0] rd;
    } d_t;

    logic        i_Clock, i_Reset;
    logic        i_Inst_Req;
    logic [31:0] i_Inst_Address, o_Inst_Data;
    logic        o_Inst_Ready;
    logic        i_Data_Read_Enable, i_Data_Write_Enable;
    logic [31:0] i_Data_Address, i_Data_Write_Data, o_Data_Read_Data;
    logic        o_Data_Ready, o_Freeze;
    logic [31:0] o_Mem_Address, o_Mem_Write_Data, i_Mem_Read_Data;
    logic        o_Mem_Read_Enable, o_Mem_Write_Enable;

    logic        s_req, s_irdy, s_drdy, s_frz, s_mre, s_mwe;
    logic [31:0] s_iaddr, s_idata, s_rdata, s_maddr, s_mwd, s_mrd;

    int          checks = 0, errors = 0, cyc = 0, run = 0;
    logic [31:0] inst_q[$];
    d_t          data_q[$];
    logic [31:0] last_rd;
    logic        p_inst, p_data, last_data, cur_data;
    logic [33:0] s_actl;
    logic [31:0] s_wd;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h10) ? 32'hE3A0_1005 : {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    // Memory only presents the real word on the last strobe cycle.
    assign i_Mem_Read_Data = (o_Mem_Read_Enable && run == W) ? mem_word(o_Mem_Address) : ~mem_word(o_Mem_Address);
    assign s_mrd = mem_word(s_maddr);

    memory_arbiter #(.WAIT_STATES(W)) dut (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_Inst_Req(i_Inst_Req), .i_Inst_Address(i_Inst_Address),
        .o_Inst_Data(o_Inst_Data), .o_Inst_Ready(o_Inst_Ready),
        .i_Data_Read_Enable(i_Data_Read_Enable), .i_Data_Write_Enable(i_Data_Write_Enable),
        .i_Data_Address(i_Data_Address), .i_Data_Write_Data(i_Data_Write_Data),
        .o_Data_Read_Data(o_Data_Read_Data), .o_Data_Ready(o_Data_Ready), .o_Freeze(o_Freeze),
        .o_Mem_Address(o_Mem_Address), .o_Mem_Write_Data(o_Mem_Write_Data),
        .o_Mem_Read_Enable(o_Mem_Read_Enable), .o_Mem_Write_Enable(o_Mem_Write_Enable),
        .i_Mem_Read_Data(i_Mem_Read_Data)
    );

    memory_arbiter #(.WAIT_STATES(1)) dut1 (
        .i_Clock(i_Clock), .i_Reset(i_Reset),
        .i_Inst_Req(s_req), .i_Inst_Address(s_iaddr),
        .o_Inst_Data(s_idata), .o_Inst_Ready(s_irdy),
        .i_Data_Read_Enable(1'b0), .i_Data_Write_Enable(1'b0),
        .i_Data_Address(32'h0), .i_Data_Write_Data(32'h0),
        .o_Data_Read_Data(s_rdata), .o_Data_Ready(s_drdy), .o_Freeze(s_frz),
        .o_Mem_Address(s_maddr), .o_Mem_Write_Data(s_mwd),
        .o_Mem_Read_Enable(s_mre), .o_Mem_Write_Enable(s_mwe),
        .i_Mem_Read_Data(s_mrd)
    );

    initial begin
        i_Clock = 1'b0;
        forever #5 i_Clock = ~i_Clock;
    end

    always @(posedge i_Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input logic is_data, output int lat);
        int t0;
        t0 = cyc;
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            @(posedge i_Clock);
            #1;
            if (is_data ? o_Data_Ready : o_Inst_Ready) begin
                lat = cyc - t0;
                break;
            end
        end
        chk(is_data ? "data_ready_timeout" : "inst_ready_timeout", 64'(lat < 0), 64'd0);
    endtask

    task automatic inst_access(input logic [31:0] a, output int lat);
        inst_q.push_back(a);
        i_Inst_Address = a;
        i_Inst_Req = 1'b1;
        wait_ready(1'b0, lat);
        i_Inst_Req = 1'b0;
    endtask

    task automatic data_access(input logic [31:0] a, input logic [31:0] wd, input logic rd, input logic wr, output int lat);
        d_t e;
        e.a = a;
        e.w = wr;
        e.wd = wd;
        e.rd = wr ? last_rd : mem_word(a);
        if (!wr) last_rd = e.rd;
        data_q.push_back(e);
        i_Data_Address = a;
        i_Data_Write_Data = wd;
        i_Data_Read_Enable = rd;
        i_Data_Write_Enable = wr;
        wait_ready(1'b1, lat);
        i_Data_Read_Enable = 1'b0;
        i_Data_Write_Enable = 1'b0;
    endtask

    task automatic idle1();
        @(posedge i_Clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_data_outs"}, {o_Inst_Data, o_Data_Read_Data}, 64'd0);
        chk({tag, "_mem_outs"}, {o_Mem_Address, o_Mem_Write_Data}, 64'd0);
        chk({tag, "_ctl_outs"}, 64'({o_Inst_Ready, o_Data_Ready, o_Freeze, o_Mem_Read_Enable, o_Mem_Write_Enable}), 64'd0);
    endtask

    // Monitor: arbitration order, port stability, strobe length and returned data.
    always @(negedge i_Clock) begin
        logic strobe, is_data, exp_data;
        strobe = o_Mem_Read_Enable | o_Mem_Write_Enable;
        if (i_Reset) begin
            run = 0;
            last_data = 1'b0;
            p_inst = 1'b0;
            p_data = 1'b0;
        end else begin
            chk("freeze", 64'(o_Freeze), 64'((i_Data_Read_Enable | i_Data_Write_Enable) & ~o_Data_Ready));
            if (strobe && run == 0) begin
                is_data = o_Mem_Write_Enable | o_Mem_Address[31];
                exp_data = p_data & ~(FAIR & last_data & p_inst);
                chk("grant_had_request", 64'(p_data | p_inst), 64'd1);
                chk("grant_winner", 64'(is_data), 64'(exp_data));
                if (is_data) begin
                    chk("data_q_size", 64'(data_q.size() != 0), 64'd1);
                    if (data_q.size() != 0) begin
                        chk("data_start", 64'({o_Mem_Address, o_Mem_Write_Enable, o_Mem_Read_Enable}),
                            64'({data_q[0].a, data_q[0].w, ~data_q[0].w}));
                        if (data_q[0].w) chk("store_data", 64'(o_Mem_Write_Data), 64'(data_q[0].wd));
                    end
                end else begin
                    chk("inst_q_size", 64'(inst_q.size() != 0), 64'd1);
                    if (inst_q.size() != 0)
                        chk("inst_start", 64'({o_Mem_Address, o_Mem_Write_Enable, o_Mem_Read_Enable}), 64'({inst_q[0], 2'b01}));
                end
                s_actl = {o_Mem_Address, o_Mem_Write_Enable, o_Mem_Read_Enable};
                s_wd = o_Mem_Write_Data;
                cur_data = is_data;
            end else if (strobe) begin
                chk("stable_addr_ctl", 64'({o_Mem_Address, o_Mem_Write_Enable, o_Mem_Read_Enable}), 64'(s_actl));
                chk("stable_wdata", 64'(o_Mem_Write_Data), 64'(s_wd));
            end
            if (!strobe && run > 0) begin
                chk("strobe_len", 64'(run), 64'(W));
                chk("ready_after", 64'({o_Data_Ready, o_Inst_Ready}), cur_data ? 64'd2 : 64'd1);
                last_data = cur_data;
                run = 0;
            end
            if (strobe) run++;
            if (o_Inst_Ready) begin
                chk("inst_pop", 64'(inst_q.size() != 0), 64'd1);
                if (inst_q.size() != 0) chk("inst_data", 64'(o_Inst_Data), 64'(mem_word(inst_q.pop_front())));
            end
            if (o_Data_Ready) begin
                chk("data_pop", 64'(data_q.size() != 0), 64'd1);
                if (data_q.size() != 0) chk("data_read", 64'(o_Data_Read_Data), 64'(data_q.pop_front().rd));
            end
            p_inst = i_Inst_Req;
            p_data = i_Data_Read_Enable | i_Data_Write_Enable;
        end
    end

    initial begin
        int l1, l2, li, scnt, rcyc;
        i_Reset = 1'b1;
        i_Inst_Req = 1'b0;
        i_Inst_Address = '0;
        i_Data_Read_Enable = 1'b0;
        i_Data_Write_Enable = 1'b0;
        i_Data_Address = '0;
        i_Data_Write_Data = '0;
        s_req = 1'b0;
        s_iaddr = 32'h20;
        last_rd = '0;
        repeat (3) @(posedge i_Clock);
        @(negedge i_Clock);
        chk_zero("reset");
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        idle1();

        // Single wait state: one strobe cycle, ready in cycle 2.
        s_req = 1'b1;
        scnt = 0;
        rcyc = -1;
        for (int j = 0; j < 6; j++) begin
            @(negedge i_Clock);
            if (s_mre) scnt++;
            if (s_irdy && rcyc < 0) begin
                rcyc = j;
                s_req = 1'b0;
                chk("w1_data", 64'(s_idata), 64'(mem_word(32'h20)));
            end
        end
        s_req = 1'b0;
        chk("w1_strobe_cycles", 64'(scnt), 64'd1);
        chk("w1_ready_cycle", 64'(rcyc), 64'd2);
        idle1();

        inst_access(32'h10, li);
        chk("fetch_latency", 64'(li), 64'd4);
        chk("fetch_word", 64'(o_Inst_Data), 64'hE3A0_1005);
        idle1();
        data_access(32'h8000_0040, 32'h0, 1'b1, 1'b0, l1);
        chk("ldr_latency", 64'(l1), 64'd4);
        idle1();
        data_access(32'h0000_0400, 32'h0000_00AB, 1'b0, 1'b1, l1);
        chk("str_latency", 64'(l1), 64'd4);
        chk("str_keeps_read_data", 64'(o_Data_Read_Data), 64'(mem_word(32'h8000_0040)));
        idle1();
        data_access(32'h8000_0100, 32'h0000_1234, 1'b1, 1'b1, l1);
        chk("rw_latency", 64'(l1), 64'd4);
        idle1();

        fork
            inst_access(32'h0000_0100, li);
            data_access(32'h8000_0200, 32'h0, 1'b1, 1'b0, l1);
        join
        chk("both_data_latency", 64'(l1), 64'd4);
        chk("both_inst_latency", 64'(li), 64'd9);
        idle1();

        fork
            begin
                data_access(32'h8000_0300, 32'h0, 1'b1, 1'b0, l1);
                data_access(32'h8000_0304, 32'h0, 1'b1, 1'b0, l2);
            end
            inst_access(32'h0000_0200, li);
        join
        chk("cont_data1_latency", 64'(l1), 64'd4);
        chk("cont_data2_latency", 64'(l2), FAIR ? 64'd10 : 64'd5);
        chk("cont_inst_latency", 64'(li), FAIR ? 64'd9 : 64'd14);
        idle1();

        // Reset in the second busy cycle of a load aborts it completely.
        data_q.push_back('{a: 32'h8000_0500, w: 1'b0, wd: 32'h0, rd: mem_word(32'h8000_0500)});
        i_Data_Address = 32'h8000_0500;
        i_Data_Read_Enable = 1'b1;
        idle1();
        idle1();
        i_Reset = 1'b1;
        idle1();
        i_Reset = 1'b0;
        i_Data_Read_Enable = 1'b0;
        data_q.delete();
        last_rd = '0;
        @(negedge i_Clock);
        chk_zero("abort");
        repeat (6) @(posedge i_Clock);
        #1;
        inst_access(32'h0000_0044, li);
        chk("after_abort_latency", 64'(li), 64'd4);
        idle1();

        fork
            begin
                int g;
                logic [31:0] a;
                for (int n = 0; n < 40; n++) begin
                    g = $urandom_range(0, 3);
                    repeat (g) idle1();
                    a = {1'b0, 29'($urandom), 2'b00};
                    inst_access(a, li);
                end
            end
            begin
                int g, k;
                logic [31:0] a;
                for (int n = 0; n < 40; n++) begin
                    g = $urandom_range(0, 4);
                    repeat (g) idle1();
                    a = {1'b1, 29'($urandom), 2'b00};
                    k = $urandom_range(0, 2);
                    data_access(a, $urandom, k != 1, k != 0, l1);
                end
            end
        join
        repeat (10) @(posedge i_Clock);
        #1;
        chk("inst_q_drained", 64'(inst_q.size()), 64'd0);
        chk("data_q_drained", 64'(data_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
